// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
//   reg_idx_t   : 5-bit integer register index
//   xlen_t      : 32-bit register data
//   arb_state_t : arbitration state (PRI_ALU = ALU has priority, FORCE_LU = long unit forced)
//   REG_ZERO    : index of the hard-wired zero register
package wb_pkg;

  typedef logic [4:0]  reg_idx_t;
  typedef logic [31:0] xlen_t;

  typedef enum logic [0:0] {
    PRI_ALU,
    FORCE_LU
  } arb_state_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_scoreboard.sv
// Busy scoreboard for registers awaiting long-latency results, plus the
// outstanding long-op counter and the issue hazard.
// Ports:
//   clk, rsta                 : clock, asynchronous active-low reset
//   i_iss_valid, i_iss_rd     : long op issued (qualified internally by hazard)
//   i_clr_valid, i_clr_rd     : long-unit result committing to the register file
//   i_lu_xfer                 : long-unit writeback accepted this cycle
//   i_chk_rs1/rs2/rd          : decode-stage registers to check
//   o_hazard                  : issue stall (combinational)
//   o_pend_cnt                : outstanding long ops
module wb_scoreboard
  import wb_pkg::*;
#(
  parameter int unsigned MAX_PEND = 4
) (
  input  logic       clk,
  input  logic       rsta,
  input  logic       i_iss_valid,
  input  reg_idx_t   i_iss_rd,
  input  logic       i_clr_valid,
  input  reg_idx_t   i_clr_rd,
  input  logic       i_lu_xfer,
  input  reg_idx_t   i_chk_rs1,
  input  reg_idx_t   i_chk_rs2,
  input  reg_idx_t   i_chk_rd,
  output logic       o_hazard,
  output logic [3:0] o_pend_cnt
);

  localparam logic [3:0] PendMax = 4'(MAX_PEND);

  logic [31:0] r_busy_q, w_busy_d;
  logic [3:0]  r_pend_q, w_pend_d;
  logic        w_hazard;
  logic        w_iss;

  assign w_hazard = r_busy_q[i_chk_rs1] | r_busy_q[i_chk_rs2] | r_busy_q[i_chk_rd] |
                    (r_pend_q == PendMax);
  // An issue while stalled is not a real issue; it must not touch the state.
  assign w_iss    = i_iss_valid && !w_hazard;

  always_comb begin
    w_busy_d = r_busy_q;
    if (i_clr_valid && (i_clr_rd != REG_ZERO)) w_busy_d[i_clr_rd] = 1'b0;
    // Set is applied after clear so a same-edge reissue keeps the register busy.
    if (w_iss && (i_iss_rd != REG_ZERO)) w_busy_d[i_iss_rd] = 1'b1;
    w_busy_d[0] = 1'b0;
  end

  always_comb begin
    w_pend_d = r_pend_q;
    if (w_iss && !i_lu_xfer && (r_pend_q != PendMax)) begin
      w_pend_d = r_pend_q + 4'd1;
    end else if (!w_iss && i_lu_xfer && (r_pend_q != 4'd0)) begin
      w_pend_d = r_pend_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rsta) begin
    if (!rsta) begin
      r_busy_q <= '0;
      r_pend_q <= '0;
    end else begin
      r_busy_q <= w_busy_d;
      r_pend_q <= w_pend_d;
    end
  end

  assign o_hazard   = w_hazard;
  assign o_pend_cnt = r_pend_q;

endmodule

// File: rtl/wb_arbiter.sv
// Shares the single register-file write port between the ALU (source 0) and
// the long-latency unit (source 1), with starvation protection for source 1,
// and tracks registers awaiting long-latency results.
// Ports:
//   clk, rsta                        : clock, asynchronous active-low reset
//   i_alu_valid/o_alu_ready/rd/data  : ALU writeback handshake
//   i_lu_valid/o_lu_ready/rd/data    : long-unit writeback handshake
//   i_iss_valid, i_iss_rd            : long op issue
//   i_chk_rs1/rs2/rd, o_hazard       : decode-stage hazard check
//   o_RegWrite/o_write_reg/o_write_data : registered register-file write port
//   o_pend_cnt                       : outstanding long ops
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned MAX_PEND = 4
) (
  input  logic       clk,
  input  logic       rsta,
  input  logic       i_alu_valid,
  output logic       o_alu_ready,
  input  reg_idx_t   i_alu_rd,
  input  xlen_t      i_alu_data,
  input  logic       i_lu_valid,
  output logic       o_lu_ready,
  input  reg_idx_t   i_lu_rd,
  input  xlen_t      i_lu_data,
  input  logic       i_iss_valid,
  input  reg_idx_t   i_iss_rd,
  input  reg_idx_t   i_chk_rs1,
  input  reg_idx_t   i_chk_rs2,
  input  reg_idx_t   i_chk_rd,
  output logic       o_hazard,
  output logic       o_RegWrite,
  output reg_idx_t   o_write_reg,
  output xlen_t      o_write_data,
  output logic [3:0] o_pend_cnt
);

  localparam logic [3:0] WaitLast = 4'(MAX_WAIT - 1);

  arb_state_t r_state_q, w_state_d;
  logic [3:0] r_wait_q, w_wait_d;
  logic       r_regwrite_q;
  reg_idx_t   r_write_reg_q;
  xlen_t      r_write_data_q;
  logic       r_wb_from_lu_q;
  logic       w_alu_xfer;
  logic       w_lu_xfer;

  always_comb begin
    o_alu_ready = 1'b1;
    o_lu_ready  = i_lu_valid && !i_alu_valid;
    w_state_d   = r_state_q;
    unique case (r_state_q)
      PRI_ALU: begin
        if (i_lu_valid && !o_lu_ready && (r_wait_q == WaitLast)) w_state_d = FORCE_LU;
      end
      FORCE_LU: begin
        o_alu_ready = 1'b0;
        o_lu_ready  = 1'b1;
        // Leaves on the forced transfer, or if the request was withdrawn.
        w_state_d   = PRI_ALU;
      end
      default: w_state_d = PRI_ALU;
    endcase
  end

  assign w_alu_xfer = i_alu_valid && o_alu_ready;
  assign w_lu_xfer  = i_lu_valid && o_lu_ready;

  always_comb begin
    w_wait_d = r_wait_q;
    if (!i_lu_valid || w_lu_xfer) begin
      w_wait_d = 4'd0;
    end else if (r_wait_q != 4'hf) begin
      w_wait_d = r_wait_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rsta) begin
    if (!rsta) begin
      r_state_q      <= PRI_ALU;
      r_wait_q       <= '0;
      r_regwrite_q   <= 1'b0;
      r_write_reg_q  <= REG_ZERO;
      r_write_data_q <= '0;
      r_wb_from_lu_q <= 1'b0;
    end else begin
      r_state_q      <= w_state_d;
      r_wait_q       <= w_wait_d;
      r_wb_from_lu_q <= w_lu_xfer;
      if (w_lu_xfer) begin
        r_regwrite_q   <= (i_lu_rd != REG_ZERO);
        r_write_reg_q  <= i_lu_rd;
        r_write_data_q <= i_lu_data;
      end else if (w_alu_xfer) begin
        r_regwrite_q   <= (i_alu_rd != REG_ZERO);
        r_write_reg_q  <= i_alu_rd;
        r_write_data_q <= i_alu_data;
      end else begin
        r_regwrite_q   <= 1'b0;
      end
    end
  end

  // Busy is cleared on the edge the register file commits the long result.
  wb_scoreboard #(
    .MAX_PEND (MAX_PEND)
  ) u_scoreboard (
    .clk         (clk),
    .rsta        (rsta),
    .i_iss_valid (i_iss_valid),
    .i_iss_rd    (i_iss_rd),
    .i_clr_valid (r_regwrite_q && r_wb_from_lu_q),
    .i_clr_rd    (r_write_reg_q),
    .i_lu_xfer   (w_lu_xfer),
    .i_chk_rs1   (i_chk_rs1),
    .i_chk_rs2   (i_chk_rs2),
    .i_chk_rd    (i_chk_rd),
    .o_hazard    (o_hazard),
    .o_pend_cnt  (o_pend_cnt)
  );

  assign o_RegWrite   = r_regwrite_q;
  assign o_write_reg  = r_write_reg_q;
  assign o_write_data = r_write_data_q;

endmodule
